// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master issues operations; the slave (the subtractor) returns results.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, in1, in2, borrow_in,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, in1, in2, borrow_in,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: in1 - in2 - borrow_in, one bit per
// clock LSB first, through one full-subtractor cell and a borrow flop.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic accept;
  logic last_bit;
  logic d_bit;
  logic bo_bit;
  logic busy_o;
  logic done_o;

  assign accept   = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // The single full-subtractor slice shared by every bit position.
  assign d_bit  = a_q[0] ^ b_q[0] ^ br_q;
  assign bo_bit = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The counter does not advance on the final bit; it is cleared on every accept.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    br_d   = br_q;
    cnt_d  = cnt_q;
    res_d  = res_q;
    diff_d = diff_q;
    bout_d = bout_q;
    if (accept) begin
      a_d   = bus.in1;
      b_d   = bus.in2;
      br_d  = bus.borrow_in;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      a_d   = {1'b0, a_q[WIDTH-1:1]};
      b_d   = {1'b0, b_q[WIDTH-1:1]};
      br_d  = bo_bit;
      res_d = {d_bit, res_q[WIDTH-1:1]};
      if (last_bit) begin
        diff_d = {d_bit, res_q[WIDTH-1:1]};
        bout_d = bo_bit;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    busy_o = (state_q == RUN);
    done_o = (state_q == DONE);
  end

  assign bus.busy       = busy_o;
  assign bus.done       = done_o;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH = 8 and WIDTH = 5,
// with immediate assertions at every comparison point.
module tb_serial_subtractor;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(5)) bus5 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_subtractor #(.WIDTH(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Set operands and raise start at a falling edge; the next rising edge accepts.
  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic bin);
    bus8.in1       = x;
    bus8.in2       = y;
    bus8.borrow_in = bin;
    bus8.start     = 1'b1;
  endtask

  // Called at the falling edge just after the accepting edge; returns at the done cycle.
  task automatic waitDone8(input logic [7:0] hold, output int cyc, output int hold_bad,
                           output int busy_cnt);
    cyc = 0;
    hold_bad = 0;
    busy_cnt = 0;
    while (!bus8.done && cyc < 20) begin
      if (bus8.diff !== hold) hold_bad++;
      if (bus8.busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic runOp8(input logic [7:0] x, input logic [7:0] y, input logic bin,
                        output int cyc, output int hold_bad, output int busy_cnt);
    logic [7:0] hold;
    hold = bus8.diff;
    applyStimulus(x, y, bin);
    @(negedge clk);
    bus8.start = 1'b0;
    waitDone8(hold, cyc, hold_bad, busy_cnt);
  endtask

  initial begin
    int cyc, hold_bad, busy_cnt, done_cnt;
    logic [7:0] cap_diff;
    logic       cap_bout;
    logic [7:0] rx, ry;
    logic       rb;
    logic [8:0] ref9;
    logic [4:0] qx, qy;
    logic       qb;
    logic [5:0] ref6;

    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.in1 = '0; bus8.in2 = '0; bus8.borrow_in = 1'b0;
    bus5.start = 1'b0; bus5.in1 = '0; bus5.in2 = '0; bus5.borrow_in = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(bus8.busy), 32'h0);
    checkOutput("reset_done", 32'(bus8.done), 32'h0);
    checkOutput("reset_diff", 32'(bus8.diff), 32'h0);
    checkOutput("reset_bout", 32'(bus8.borrow_out), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic subtraction with latency, busy length and single-cycle done.
    runOp8(8'h5A, 8'h3C, 1'b0, cyc, hold_bad, busy_cnt);
    checkOutput("basic_latency", 32'(cyc), 32'd8);
    checkOutput("basic_busy_cycles", 32'(busy_cnt), 32'd8);
    checkOutput("basic_diff_hold", 32'(hold_bad), 32'd0);
    checkOutput("basic_busy_in_done", 32'(bus8.busy), 32'h0);
    checkOutput("basic_diff", 32'(bus8.diff), 32'h1E);
    checkOutput("basic_bout", 32'(bus8.borrow_out), 32'h0);
    @(negedge clk);
    checkOutput("basic_done_one_cycle", 32'(bus8.done), 32'h0);
    checkOutput("basic_idle_busy", 32'(bus8.busy), 32'h0);
    checkOutput("basic_idle_hold", 32'(bus8.diff), 32'h1E);

    // Underflow and borrow chain.
    runOp8(8'h00, 8'h01, 1'b0, cyc, hold_bad, busy_cnt);
    checkOutput("uflow_diff", 32'(bus8.diff), 32'hFF);
    checkOutput("uflow_bout", 32'(bus8.borrow_out), 32'h1);
    @(negedge clk);
    runOp8(8'h10, 8'h10, 1'b1, cyc, hold_bad, busy_cnt);
    checkOutput("eq_bin_diff", 32'(bus8.diff), 32'hFF);
    checkOutput("eq_bin_bout", 32'(bus8.borrow_out), 32'h1);
    checkOutput("eq_bin_hold", 32'(hold_bad), 32'd0);
    @(negedge clk);
    runOp8(8'hFF, 8'h00, 1'b1, cyc, hold_bad, busy_cnt);
    checkOutput("ff_bin_diff", 32'(bus8.diff), 32'hFE);
    checkOutput("ff_bin_bout", 32'(bus8.borrow_out), 32'h0);
    @(negedge clk);

    // Start during RUN must be dropped.
    applyStimulus(8'h5A, 8'h3C, 1'b0);
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(8'h01, 8'h02, 1'b0);
    @(negedge clk);
    bus8.start = 1'b0;
    done_cnt = 0;
    cap_diff = 8'h00;
    cap_bout = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus8.done) begin
        done_cnt++;
        cap_diff = bus8.diff;
        cap_bout = bus8.borrow_out;
      end
      @(negedge clk);
    end
    checkOutput("busyprot_done_count", 32'(done_cnt), 32'd1);
    checkOutput("busyprot_diff", 32'(cap_diff), 32'h1E);
    checkOutput("busyprot_bout", 32'(cap_bout), 32'h0);

    // Back-to-back with start held through the DONE cycle.
    applyStimulus(8'h80, 8'h01, 1'b0);
    @(negedge clk);
    waitDone8(8'h1E, cyc, hold_bad, busy_cnt);
    checkOutput("b2b_first_latency", 32'(cyc), 32'd8);
    checkOutput("b2b_first_diff", 32'(bus8.diff), 32'h7F);
    checkOutput("b2b_first_bout", 32'(bus8.borrow_out), 32'h0);
    applyStimulus(8'h03, 8'h05, 1'b0);
    @(negedge clk);
    bus8.start = 1'b0;
    checkOutput("b2b_second_busy", 32'(bus8.busy), 32'h1);
    waitDone8(8'h7F, cyc, hold_bad, busy_cnt);
    checkOutput("b2b_second_latency", 32'(cyc), 32'd8);
    checkOutput("b2b_hold_7f", 32'(hold_bad), 32'd0);
    checkOutput("b2b_second_diff", 32'(bus8.diff), 32'hFE);
    checkOutput("b2b_second_bout", 32'(bus8.borrow_out), 32'h1);
    @(negedge clk);

    // Asynchronous reset in the middle of an operation.
    applyStimulus(8'hAA, 8'h55, 1'b0);
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(bus8.busy), 32'h0);
    checkOutput("midrst_done", 32'(bus8.done), 32'h0);
    checkOutput("midrst_diff", 32'(bus8.diff), 32'h00);
    checkOutput("midrst_bout", 32'(bus8.borrow_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus8.done || bus8.busy) done_cnt++;
      @(negedge clk);
    end
    checkOutput("midrst_no_done", 32'(done_cnt), 32'd0);
    checkOutput("midrst_diff_after", 32'(bus8.diff), 32'h00);
    runOp8(8'h5A, 8'h3C, 1'b0, cyc, hold_bad, busy_cnt);
    checkOutput("postrst_latency", 32'(cyc), 32'd8);
    checkOutput("postrst_diff", 32'(bus8.diff), 32'h1E);
    checkOutput("postrst_bout", 32'(bus8.borrow_out), 32'h0);

    // Random operands at WIDTH = 8 against a wide-arithmetic reference.
    for (int i = 0; i < 1000; i++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      rb = 1'($urandom);
      ref9 = {1'b0, rx} - {1'b0, ry} - {8'b0, rb};
      runOp8(rx, ry, rb, cyc, hold_bad, busy_cnt);
      checkOutput("rand8_latency", 32'(cyc), 32'd8);
      checkOutput("rand8_diff", 32'(bus8.diff), 32'(ref9[7:0]));
      checkOutput("rand8_bout", 32'(bus8.borrow_out), 32'(ref9[8]));
    end
    @(negedge clk);

    // Random operands at WIDTH = 5.
    for (int i = 0; i < 1000; i++) begin
      qx = 5'($urandom);
      qy = 5'($urandom);
      qb = 1'($urandom);
      ref6 = {1'b0, qx} - {1'b0, qy} - {5'b0, qb};
      bus5.in1 = qx;
      bus5.in2 = qy;
      bus5.borrow_in = qb;
      bus5.start = 1'b1;
      @(negedge clk);
      bus5.start = 1'b0;
      cyc = 0;
      while (!bus5.done && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      checkOutput("rand5_latency", 32'(cyc), 32'd5);
      checkOutput("rand5_diff", 32'(bus5.diff), 32'(ref6[4:0]));
      checkOutput("rand5_bout", 32'(bus5.borrow_out), 32'(ref6[5]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
